// File: rtl/fir_queue_pkg.sv
// rtl/fir_queue_pkg.sv - shared types and default sizing for the FIR sample queue
// Purpose: queue state encoding, default geometry and pointer-width helper.
// Ports: none (package).
package fir_queue_pkg;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    IDLE = 2'd1,
    READ = 2'd2
  } queue_state_t;

  localparam int DEPTH_DEF  = 1024;
  localparam int TAPS_DEF   = 1021;
  localparam int DATA_W_DEF = 16;

  function automatic int ptr_width(input int depth);
    return $clog2(depth);
  endfunction

  localparam int PTR_W_DEF = ptr_width(DEPTH_DEF);

endpackage

// File: rtl/queue_dpram.sv
// rtl/queue_dpram.sv - simple dual-port RAM holding packed stereo samples
// Purpose: one write port, one synchronous read port (1-cycle latency).
// Ports:
//   clk      - clock
//   rst      - synchronous active-high reset, clears the read data register only
//   wr_en    - write strobe
//   wr_addr  - write slot
//   wr_data  - packed {left, right} sample
//   rd_en    - read strobe; rd_data holds while low
//   rd_addr  - read slot
//   rd_data  - registered read data
module queue_dpram #(
  parameter int DEPTH = 1024,
  parameter int WIDTH = 32,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Storage array has no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/fir_sample_queue.sv
// rtl/fir_sample_queue.sv - circular stereo sample queue streaming FIR windows
// Purpose: stores incoming samples and, per new sample once TAPS are held,
//   streams the last TAPS samples oldest-first while sequencing is high.
// Optional feature macro: SEQ_OVERRUN_DET_EN (sticky dropped-pass flag).
// Ports:
//   clk        - clock
//   rst        - synchronous active-high reset
//   new_smpl   - one-cycle strobe, lft_in/rht_in valid
//   lft_in     - left sample
//   rht_in     - right sample
//   sequencing - high while lft_out/rht_out carry pass data
//   lft_out    - left sample stream
//   rht_out    - right sample stream
//   seq_done   - one-cycle pulse after the last sample of a pass
//   overrun    - sticky dropped-pass flag (0 when the feature is disabled)
module fir_sample_queue
  import fir_queue_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int TAPS   = TAPS_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     new_smpl,
  input  logic signed [DATA_W-1:0] lft_in,
  input  logic signed [DATA_W-1:0] rht_in,
  output logic                     sequencing,
  output logic signed [DATA_W-1:0] lft_out,
  output logic signed [DATA_W-1:0] rht_out,
  output logic                     seq_done,
  output logic                     overrun
);

  localparam int PTR_W  = ptr_width(DEPTH);
  localparam int CNT_W  = $clog2(TAPS + 1);
  localparam int RCNT_W = $clog2(TAPS);

  queue_state_t      state;
  logic [PTR_W-1:0]  wptr;
  logic [PTR_W-1:0]  rptr;
  logic [CNT_W-1:0]  count;
  logic [RCNT_W-1:0] rcnt;
  logic              pending;
  logic              hold;

  logic              rd_en;
  logic              last_rd;
  logic [PTR_W-1:0]  newest;
  logic [PTR_W-1:0]  start_next;
  logic [2*DATA_W-1:0] rd_data;

  // hold is the one idle cycle forced between back-to-back passes.
  assign rd_en   = (state == READ) && !hold;
  assign last_rd = rd_en && (rcnt == RCNT_W'(TAPS - 1));

  // Window ends at the most recent sample, counting one being written now.
  assign newest     = new_smpl ? wptr : (wptr - PTR_W'(1));
  assign start_next = newest - PTR_W'(TAPS - 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= FILL;
      wptr       <= '0;
      rptr       <= '0;
      count      <= '0;
      rcnt       <= '0;
      pending    <= 1'b0;
      hold       <= 1'b0;
      sequencing <= 1'b0;
      seq_done   <= 1'b0;
    end else begin
      if (new_smpl) begin
        wptr <= wptr + PTR_W'(1);
      end

      // RAM data appears one cycle after the read, so sequencing follows rd_en.
      sequencing <= rd_en;
      seq_done   <= sequencing && !rd_en;

      case (state)
        FILL: begin
          if (new_smpl) begin
            count <= count + CNT_W'(1);
            if (count == CNT_W'(TAPS - 1)) begin
              state <= READ;
              rptr  <= start_next;
              rcnt  <= '0;
              hold  <= 1'b0;
            end
          end
        end
        IDLE: begin
          if (new_smpl) begin
            state <= READ;
            rptr  <= start_next;
            rcnt  <= '0;
            hold  <= 1'b0;
          end
        end
        READ: begin
          if (hold) begin
            hold <= 1'b0;
            if (new_smpl) begin
              pending <= 1'b1;
            end
          end else begin
            rptr <= rptr + PTR_W'(1);
            rcnt <= rcnt + RCNT_W'(1);
            if (last_rd) begin
              pending <= 1'b0;
              if (pending || new_smpl) begin
                rptr <= start_next;
                rcnt <= '0;
                hold <= 1'b1;
              end else begin
                state <= IDLE;
              end
            end else if (new_smpl) begin
              pending <= 1'b1;
            end
          end
        end
        default: begin
          state <= FILL;
        end
      endcase
    end
  end

`ifdef SEQ_OVERRUN_DET_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      overrun <= 1'b0;
    end else if ((state == READ) && pending && new_smpl) begin
      overrun <= 1'b1;
    end
  end
`else
  assign overrun = 1'b0;
`endif

  queue_dpram #(
    .DEPTH (DEPTH),
    .WIDTH (2 * DATA_W),
    .ADDR_W(PTR_W)
  ) u_ram (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (new_smpl),
    .wr_addr(wptr),
    .wr_data({lft_in, rht_in}),
    .rd_en  (rd_en),
    .rd_addr(rptr),
    .rd_data(rd_data)
  );

  assign lft_out = rd_data[2*DATA_W-1:DATA_W];
  assign rht_out = rd_data[DATA_W-1:0];

endmodule

// File: doc/fir_sample_queue.md
# fir_sample_queue

Circular sample queue that feeds the high-pass/low-pass FIR filters. Stores incoming stereo samples in a dual-port RAM and, on every new sample once the window is full, streams the last TAPS samples (oldest first) to the filter, one per clock, while asserting `sequencing`. It is the producer end of the filter's `sequencing`/sample interface. The filter's coefficient index advances in lockstep with this stream.

## Interface
- `DEPTH`, 1024: RAM entries per channel; power of two.
- `TAPS`, 1021: samples per filter pass; must satisfy `TAPS <= DEPTH-2`.
- `DATA_W`, 16: sample width, signed.

Ports:
- `clk` in 1: single clock; all logic is posedge.
- `rst` in 1: reset, synchronous, active-high.
- `new_smpl` in 1: one-cycle strobe; `lft_in`/`rht_in` are valid this cycle.
- `lft_in` in DATA_W: left sample.
- `rht_in` in DATA_W: right sample.
- `sequencing` out 1: high while `lft_out`/`rht_out` carry pass data.
- `lft_out` out DATA_W: left sample stream to the filter.
- `rht_out` out DATA_W: right sample stream to the filter.
- `seq_done` out 1: one-cycle pulse after the last sample of a pass.
- `overrun` out 1: sticky flag for a dropped pass; see Configuration.

## Operation
- Reset values:
  - `sequencing`=0, `seq_done`=0, `overrun`=0, `lft_out`=`rht_out`=0.
  - Write pointer `wptr`=0, fill count=0, pending=0, state FILL.
  - RAM contents are not cleared.
- Write path:
  - Every `new_smpl` writes L/R to slot `wptr`, then `wptr` advances by 1 modulo DEPTH.
  - The write path is independent of state, so writes are never blocked.
- States:
  - FILL: count increments per write, saturating at TAPS. The write that makes count==TAPS triggers a pass and moves to READ.
  - IDLE: any `new_smpl` triggers a pass and moves to READ.
  - READ: TAPS reads are issued, oldest first. After the final read address, go to READ if pending is set (clearing it), else to IDLE.
- Pass window:
  - A trigger write at slot w latches `start = (w - TAPS + 1) mod DEPTH`.
  - Reads cover `start` .. w ascending, wrapping modulo DEPTH.
  - Samples written during a pass land outside the window, which is guaranteed by `TAPS <= DEPTH-2`.
- `new_smpl` during READ:
  - The sample is written and pending is set.
  - The next pass starts back-to-back and covers the window ending at the newest sample.
- A second `new_smpl` during READ while pending=1: the sample is written, no extra pass is queued, and an overrun is recorded.
- Reset mid-pass: `sequencing` is 0 in the cycle after `rst`; count returns to 0, so a full refill is required.

## Timing
- RAM read latency is 1 cycle. `lft_out`/`rht_out` and `sequencing` are registered and aligned with each other.
- Trigger `new_smpl` at cycle N:
  - Read address `start` is issued at N+1.
  - `sequencing`=1 with the oldest sample at N+2.
  - `sequencing` stays high for exactly TAPS cycles, N+2 .. N+TAPS+1.
  - `seq_done` pulses at N+TAPS+2.
- Back-to-back pass: `sequencing` drops for exactly 1 cycle between passes (the `seq_done` cycle).
- `lft_out`/`rht_out` hold their last value while `sequencing`=0.

## Configuration
- `SEQ_OVERRUN_DET_EN` defined: `overrun` is set on the dropped-pass condition, sticky until `rst`.
- `SEQ_OVERRUN_DET_EN` undefined: `overrun` is tied to 0 and the detection logic is absent. Dropped-pass behaviour is otherwise identical.

## Structure
- Package `fir_queue_pkg` holds:
  - state enum FILL/IDLE/READ;
  - default DEPTH, TAPS, DATA_W constants;
  - the pointer width `$clog2(DEPTH)`.
- Sub-module `queue_dpram`: one write port, one synchronous read port, `2*DATA_W` wide, DEPTH deep.
- Control logic and pointers stay in `fir_sample_queue`.

## Test plan
- Fill: 1020 `new_smpl` with values 1..1020 -> `sequencing` never asserts. Sample 1021 -> `sequencing` high for 1021 cycles starting 2 cycles later, outputs 1..1021 in order, then `seq_done` pulses once.
- Wrap: 1030 samples spaced 2000 cycles apart -> the last pass outputs 10..1030 across the RAM wrap, with no gaps or duplicates.
- Back-to-back: one `new_smpl` (value 5000) mid-pass -> the second pass starts after a 1-cycle low gap and ends with 5000; `overrun`=0.
- Overrun: two `new_smpl` in one pass -> one extra pass only, ending with the newer sample. `overrun`=1 with `SEQ_OVERRUN_DET_EN`, 0 without.
- Reset mid-pass: `rst` at pass cycle 300 -> `sequencing`=0 the next cycle and all outputs at reset values. The refill then requires 1021 new samples before the next pass.
